// File: rtl/dec_input_key_multi_if.sv
// rtl/dec_input_key_multi_if.sv - key command and decode status bundle for dec_input_key_multi
interface dec_input_key_multi_if #(
    parameter int KEY_W  = 5,
    parameter int MODE_W = 2,
    parameter int FAIL_W = 2
);
    logic [KEY_W-1:0]  InputKey;
    logic              ValidCmd;
    logic              Active;
    logic [MODE_W-1:0] Mode;
    logic              Locked;
    logic [FAIL_W-1:0] FailCnt;

    modport master (
        output InputKey, ValidCmd,
        input  Active, Mode, Locked, FailCnt
    );

    modport slave (
        input  InputKey, ValidCmd,
        output Active, Mode, Locked, FailCnt
    );
endinterface

// File: rtl/dec_input_key_multi.sv
// rtl/dec_input_key_multi.sv - multi-slot key decoder with deactivation key and timed lockout
module dec_input_key_multi #(
    parameter int                         KEY_W       = 5,
    parameter int                         N_MODES     = 4,
    parameter logic [N_MODES*KEY_W-1:0]   KEYS        = {5'b10000, 5'b00101, 5'b00001, 5'b10101},
    parameter logic [KEY_W-1:0]           DEACT_KEY   = 5'b11111,
    parameter int                         MAX_FAIL    = 3,
    parameter int                         LOCK_CYCLES = 8
) (
    input logic                   Clk,
    input logic                   Reset,
    dec_input_key_multi_if.slave  bus
);
    localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_LOCKED
    } state_t;

    state_t            state;
    logic              active_q;
    logic              locked_q;
    logic [MODE_W-1:0] mode_q;
    logic [FAIL_W-1:0] fail_q;
    logic [LOCK_W-1:0] lock_cnt;

    logic              hit;
    logic [MODE_W-1:0] hit_idx;
    logic [FAIL_W-1:0] fail_inc;

    // Scan from the top slot down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_MODES - 1; i >= 0; i--) begin
            if (bus.InputKey == KEYS[i*KEY_W +: KEY_W]) begin
                hit     = 1'b1;
                hit_idx = MODE_W'(i);
            end
        end
    end

    // In IDLE the count is always below MAX_FAIL, so the increment cannot overflow FAIL_W.
    assign fail_inc = fail_q + 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            active_q <= 1'b0;
            locked_q <= 1'b0;
            mode_q   <= '0;
            fail_q   <= '0;
            lock_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.ValidCmd) begin
                        if (hit) begin
                            state    <= S_ACTIVE;
                            active_q <= 1'b1;
                            mode_q   <= hit_idx;
                            fail_q   <= '0;
                        end else if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                            state    <= S_LOCKED;
                            locked_q <= 1'b1;
                            lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
                            fail_q   <= FAIL_W'(MAX_FAIL);
                        end else begin
                            fail_q   <= fail_inc;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (bus.ValidCmd) begin
                        if (bus.InputKey == DEACT_KEY) begin
                            state    <= S_IDLE;
                            active_q <= 1'b0;
                            mode_q   <= '0;
                        end else if (hit) begin
                            mode_q   <= hit_idx;
                        end
                    end
                end
                S_LOCKED: begin
                    if (lock_cnt == '0) begin
                        state    <= S_IDLE;
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    active_q <= 1'b0;
                    locked_q <= 1'b0;
                    mode_q   <= '0;
                    fail_q   <= '0;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.Active  = active_q;
    assign bus.Locked  = locked_q;
    assign bus.Mode    = mode_q;
    assign bus.FailCnt = fail_q;
endmodule

// File: tb/tb_dec_input_key_multi.sv
// tb/tb_dec_input_key_multi.sv - bench for dec_input_key_multi, default and re-parametrised instances
module tb_dec_input_key_multi;
    localparam logic [4:0] DEACT_A    = 5'b11111;
    localparam int         MAX_FAIL_A = 3;
    localparam int         LOCK_A     = 8;

    logic clk;
    logic rst;

    dec_input_key_multi_if #(.KEY_W(5), .MODE_W(2), .FAIL_W(2)) ifa ();
    dec_input_key_multi_if #(.KEY_W(8), .MODE_W(2), .FAIL_W(1)) ifb ();

    dec_input_key_multi dut_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifa.slave)
    );

    dec_input_key_multi #(
        .KEY_W       (8),
        .N_MODES     (3),
        .KEYS        ({8'hC3, 8'h5A, 8'h5A}),
        .DEACT_KEY   (8'hFF),
        .MAX_FAIL    (1),
        .LOCK_CYCLES (1)
    ) dut_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model of instance A: plain flags and a remaining-locked-cycles count.
    logic [4:0] keys_a [4] = '{5'b10101, 5'b00001, 5'b00101, 5'b10000};
    bit m_active;
    bit m_locked;
    int m_mode;
    int m_fail;
    int m_lock_left;

    function automatic int find_a(input logic [4:0] k);
        for (int i = 0; i < 4; i++) if (keys_a[i] == k) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_mode = 0; m_fail = 0; m_lock_left = 0;
    endtask

    task automatic model_step(input bit v, input logic [4:0] k);
        int idx;
        idx = find_a(k);
        if (m_locked) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_locked = 0;
                m_fail   = 0;
            end
        end else if (v) begin
            if (m_active) begin
                if (k == DEACT_A) begin
                    m_active = 0;
                    m_mode   = 0;
                end else if (idx >= 0) begin
                    m_mode = idx;
                end
            end else if (idx >= 0) begin
                m_active = 1;
                m_mode   = idx;
                m_fail   = 0;
            end else begin
                m_fail++;
                if (m_fail == MAX_FAIL_A) begin
                    m_locked    = 1;
                    m_lock_left = LOCK_A;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_a();
        chk("a_active", int'(ifa.Active), int'(m_active));
        chk("a_mode", int'(ifa.Mode), m_mode);
        chk("a_locked", int'(ifa.Locked), int'(m_locked));
        chk("a_failcnt", int'(ifa.FailCnt), m_fail);
    endtask

    task automatic cyc(input bit v, input logic [4:0] k);
        ifa.ValidCmd = v;
        ifa.InputKey = k;
        @(posedge clk);
        #1 model_step(v, k);
        @(negedge clk);
        cmp_a();
    endtask

    task automatic cyc_b(input bit v, input logic [7:0] k);
        ifb.ValidCmd = v;
        ifb.InputKey = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raise reset between edges and check that outputs clear before any further clock edge.
    task automatic async_rst();
        ifa.ValidCmd = 1'b0;
        ifb.ValidCmd = 1'b0;
        @(posedge clk);
        #1 model_step(1'b0, 5'b0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_active", int'(ifa.Active), 0);
        chk("rst_mode", int'(ifa.Mode), 0);
        chk("rst_locked", int'(ifa.Locked), 0);
        chk("rst_failcnt", int'(ifa.FailCnt), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.ValidCmd = 1'b0; ifa.InputKey = '0;
        ifb.ValidCmd = 1'b0; ifb.InputKey = '0;
        model_reset();
        @(negedge clk);
        chk("reset_active", int'(ifa.Active), 0);
        chk("reset_mode", int'(ifa.Mode), 0);
        chk("reset_locked", int'(ifa.Locked), 0);
        chk("reset_failcnt", int'(ifa.FailCnt), 0);
        rst = 1'b0;

        // Activate, switch modes, ignore unknown key, deactivate.
        cyc(1, 5'b10101); chk("act_active", int'(ifa.Active), 1); chk("act_mode", int'(ifa.Mode), 0);
        cyc(1, 5'b00101); chk("sw_mode2", int'(ifa.Mode), 2);
        cyc(1, 5'b10000); chk("sw_mode3", int'(ifa.Mode), 3);
        cyc(1, 5'b01010); chk("ign_mode3", int'(ifa.Mode), 3);
        cyc(1, 5'b11111); chk("deact_active", int'(ifa.Active), 0); chk("deact_mode", int'(ifa.Mode), 0);

        // Lockout and its exact duration.
        cyc(1, 5'b01010); chk("lk_fail1", int'(ifa.FailCnt), 1);
        cyc(1, 5'b01010); chk("lk_fail2", int'(ifa.FailCnt), 2);
        cyc(1, 5'b01010); chk("lk_locked", int'(ifa.Locked), 1); chk("lk_fail3", int'(ifa.FailCnt), 3);
        cyc(1, 5'b10101); chk("lk_ignore", int'(ifa.Active), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 5'b0);
            chk("lk_hold", int'(ifa.Locked), 1);
        end
        cyc(0, 5'b0); chk("lk_release", int'(ifa.Locked), 0); chk("lk_fail0", int'(ifa.FailCnt), 0);

        // Success clears the failure count.
        cyc(1, 5'b01010); cyc(1, 5'b01010);
        cyc(1, 5'b00001); chk("fr_active", int'(ifa.Active), 1); chk("fr_mode", int'(ifa.Mode), 1);
        chk("fr_fail0", int'(ifa.FailCnt), 0);
        cyc(1, 5'b11111);
        cyc(1, 5'b01010); chk("fr_fail1", int'(ifa.FailCnt), 1); chk("fr_nolock", int'(ifa.Locked), 0);

        // Async reset while ACTIVE mode 3, then at lock cycle 4.
        cyc(1, 5'b10000); chk("ar_mode3", int'(ifa.Mode), 3);
        async_rst();
        cyc(1, 5'b01010); cyc(1, 5'b01010); cyc(1, 5'b01010);
        cyc(0, 5'b0); cyc(0, 5'b0); cyc(0, 5'b0);
        chk("ar_lock4", int'(ifa.Locked), 1);
        async_rst();
        cyc(1, 5'b10101); chk("ar_first_cmd", int'(ifa.Active), 1);
        cyc(1, 5'b11111);

        // Randomised traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            logic [4:0] k;
            int r;
            r = $urandom_range(0, 7);
            if (r < 4)       k = keys_a[r];
            else if (r == 4) k = DEACT_A;
            else             k = 5'($urandom);
            if ($urandom_range(0, 149) == 0) async_rst();
            else cyc(1'($urandom_range(0, 1)), k);
        end

        // Re-parametrised instance: duplicate slot, single-failure one-cycle lockout.
        ifa.ValidCmd = 1'b0;
        cyc_b(1, 8'h5A); chk("b_dup_active", int'(ifb.Active), 1); chk("b_dup_mode", int'(ifb.Mode), 0);
        cyc_b(1, 8'hC3); chk("b_mode2", int'(ifb.Mode), 2);
        cyc_b(1, 8'hFF); chk("b_deact", int'(ifb.Active), 0);
        cyc_b(1, 8'h00); chk("b_locked", int'(ifb.Locked), 1); chk("b_fail1", int'(ifb.FailCnt), 1);
        cyc_b(0, 8'h00); chk("b_unlock", int'(ifb.Locked), 0); chk("b_fail0", int'(ifb.FailCnt), 0);
        cyc_b(1, 8'hC3); chk("b_after_lock", int'(ifb.Active), 1); chk("b_after_mode", int'(ifb.Mode), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dec_input_key_multi.md
# dec_input_key_multi

Parametrised key-decode controller. It compares each qualified `InputKey` command against a table of `N_MODES` stored keys. A match activates the block in the corresponding mode; a dedicated deactivation key returns it to idle. Repeated wrong keys while idle trigger a timed lockout. The block sits between the key-entry front end and the mode-dependent datapath, and supersedes the fixed 5-bit, single-mode key decoder.

## Interface
- `KEY_W`, 5: key width in bits (≥1).
- `N_MODES`, 4: number of key slots / modes (≥1).
- `KEYS`, {5'b10000,5'b00101,5'b00001,5'b10101}: flattened `N_MODES*KEY_W` key table; slot i = `KEYS[i*KEY_W +: KEY_W]`.
- `DEACT_KEY`, 5'b11111: key that deactivates from ACTIVE.
- `MAX_FAIL`, 3: consecutive wrong keys in IDLE before lockout (≥1).
- `LOCK_CYCLES`, 8: lockout duration in clock cycles (≥1).
- Derived: `MODE_W = max(1, clog2(N_MODES))`, `FAIL_W = clog2(MAX_FAIL+1)`, `LOCK_W = max(1, clog2(LOCK_CYCLES))`.

Ports:
- `Clk`, in, 1: clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `InputKey`, in, `KEY_W`: key value, sampled only when `ValidCmd`=1.
- `ValidCmd`, in, 1: command qualifier; each cycle it is high is one command (level, not edge).
- `Active`, out, 1: block is in ACTIVE.
- `Mode`, out, `MODE_W`: index of the matched slot; 0 when not ACTIVE.
- `Locked`, out, 1: block is in LOCKED.
- `FailCnt`, out, `FAIL_W`: current consecutive-failure count.

## Operation
- States: IDLE, ACTIVE, LOCKED. All outputs are registered and decoded from state/registers.
- Reset (async, any time, mid-lockout included): state=IDLE, `Active`=0, `Mode`=0, `Locked`=0, `FailCnt`=0, lock counter=0.
- Match: `InputKey` equals slot i. On duplicate keys the lowest matching index wins.
- IDLE, `ValidCmd`=1:
  - Match i: go to ACTIVE, `Mode`←i, `FailCnt`←0.
  - No match, `FailCnt`+1 < `MAX_FAIL`: `FailCnt`++ and stay in IDLE.
  - No match, `FailCnt`+1 = `MAX_FAIL`: go to LOCKED, lock counter←`LOCK_CYCLES`-1, `FailCnt`←`MAX_FAIL`.
  - `DEACT_KEY` carries no special meaning in IDLE. It counts as a failure unless it also matches a slot.
- ACTIVE, `ValidCmd`=1:
  - `InputKey`=`DEACT_KEY`: go to IDLE, `Mode`←0. This has priority over any slot match.
  - Else match j: stay in ACTIVE, `Mode`←j (includes j = current mode, no change).
  - Else: ignored. `FailCnt` is untouched and stays 0.
- LOCKED:
  - `ValidCmd` and `InputKey` are ignored.
  - Lock counter decrements every cycle.
  - Cycle in which counter=0: go to IDLE and set `FailCnt`←0.
- `ValidCmd`=0: no state change, except the LOCKED countdown.
- `FailCnt` saturates at `MAX_FAIL` and never wraps.
- The lock counter only counts down from `LOCK_CYCLES`-1, so it never wraps.

## Timing
- Latency is 1 cycle. A command sampled at rising edge k is visible on all outputs after edge k.
- Commands are accepted on consecutive cycles with no back-pressure.
- LOCKED duration: `Locked`=1 for exactly `LOCK_CYCLES` cycles, from the edge of the failing command. `Locked` falls at the edge where the counter reaches 0.
- A `ValidCmd` on the first IDLE cycle after lockout is processed normally.
- Reset is asynchronous: outputs clear immediately, without waiting for a clock edge. Deassertion is expected to be synchronous to `Clk` (synchronised upstream).
- The first command is accepted at the first rising edge after `Reset` falls.

## Test plan
Default parameters throughout (slot0=10101, slot1=00001, slot2=00101, slot3=10000, `DEACT_KEY`=11111, `MAX_FAIL`=3, `LOCK_CYCLES`=8).
- **Activate:** Reset 1→0, then `ValidCmd`=1 with key 10101 for one cycle → one cycle later `Active`=1, `Mode`=0, `FailCnt`=0.
- **Mode switch and deactivate:** In ACTIVE, key 00101 → `Mode`=2. Key 10000 → `Mode`=3. Key 01010 → no change. Key 11111 → `Active`=0, `Mode`=0.
- **Lockout:** From IDLE, key 01010 for 3 consecutive cycles → `FailCnt` goes 1, 2, then `Locked`=1. Key 10101 applied during lock → ignored. `Locked` stays 1 for exactly 8 cycles, then IDLE with `FailCnt`=0.
- **Failure reset on success:** Two wrong keys (`FailCnt`=2), then key 00001 → `Active`=1, `Mode`=1, `FailCnt`=0. Deactivate, then one wrong key → `FailCnt`=1 and no lock.
- **Async reset mid-operation:** Pulse `Reset` between clock edges while ACTIVE `Mode`=3, and again at lock cycle 4 → all outputs 0 immediately, state IDLE.
- **Re-parametrisation:** `KEY_W`=8, `N_MODES`=3, slots {8'h5A, 8'h5A, 8'hC3} (slot 0 = 8'h5A, slot 1 = 8'h5A, slot 2 = 8'hC3), `MAX_FAIL`=1, `LOCK_CYCLES`=1:
  - Key 5A → `Mode`=0 (lowest index wins on the duplicate key).
  - Single wrong key from IDLE → `Locked`=1 for one cycle.
